// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int RXV  = 0;
  localparam int FERR = 1;
  localparam int OVR  = 2;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Peripheral-bus view of the UART receiver: load/store decode, read data and interrupt.
interface uart_rx_if;

  logic        uart_sel;
  logic        rd;
  logic        wr;
  logic        reg_sel;
  logic [31:0] data_out;
  logic        rx_int;

  modport master (
    output uart_sel, rd, wr, reg_sel,
    input  data_out, rx_int
  );

  modport slave (
    input  uart_sel, rd, wr, reg_sel,
    output data_out, rx_int
  );

endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO; a push on a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with CPU-readable DATA/STATUS registers and a level interrupt.
// Define UART_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH FIFO.
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | timing to mid start bit, rejecting glitches
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | sampling stop bit, then push or flag framing error
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.slave   bus
);

  if (CLKS_PER_BIT < 4 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be >= 4 and FIFO_DEPTH a power of two >= 2");
  end

  localparam int             CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL_TC = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state;
  rx_state_e     state_nxt;
  logic          rx_meta;
  logic          rx_s;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          cnt_clr;
  logic          bit_shift;
  logic          push_req;
  logic          ferr_set;

  logic          rd_access;
  logic          data_rd;
  logic          status_rd;
  logic          pop;
  logic          rx_valid;
  logic          buf_full;
  logic [7:0]    head;
  logic          frame_err;
  logic          overrun;
  logic          ovr_set;
  logic [31:0]   status_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_shift = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_nxt = START;
          cnt_clr   = 1'b1;
        end
      end
      START: begin
        if (cnt == HALF_TC) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            cnt_clr   = 1'b1;
          end
        end
      end
      DATA: begin
        if (cnt == FULL_TC) begin
          bit_shift = 1'b1;
          cnt_clr   = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_TC) begin
          state_nxt = IDLE;
          if (rx_s) push_req = 1'b1;
          else      ferr_set = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // IDLE holds the counter at zero so every state starts from a cleared count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (cnt_clr || state == IDLE) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (bit_shift) begin
        shreg[bit_cnt] <= rx_s;
        bit_cnt        <= bit_cnt + 1'b1;
      end
    end
  end

  assign rd_access = bus.uart_sel & bus.rd & ~bus.wr;
  assign data_rd   = rd_access & (bus.reg_sel == REG_DATA);
  assign status_rd = rd_access & (bus.reg_sel == REG_STATUS);
  assign pop       = data_rd & rx_valid;

`ifdef UART_RX_FIFO_EN
  logic buf_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (shreg),
    .pop   (pop),
    .dout  (head),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign rx_valid = ~buf_empty;
`else
  logic [7:0] hold;
  logic       hold_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (push_req && (!hold_vld || pop)) begin
      hold     <= shreg;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end

  assign head     = hold;
  assign rx_valid = hold_vld;
  assign buf_full = hold_vld;
`endif

  assign ovr_set = push_req & buf_full & ~pop;

  // A new error raised in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~status_rd);
      overrun   <= ovr_set  | (overrun   & ~status_rd);
    end
  end

  always_comb begin
    status_word       = '0;
    status_word[RXV]  = rx_valid;
    status_word[FERR] = frame_err;
    status_word[OVR]  = overrun;
  end

  always_comb begin
    bus.data_out = '0;
    if (data_rd && rx_valid) bus.data_out = {24'b0, head};
    else if (status_rd)      bus.data_out = status_word;
  end

  assign bus.rx_int = rx_valid;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit; register reads are checked by a negedge monitor.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = 16;
  localparam int NONE = -100;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_exp;

  uart_rx_if bus ();

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.uart_sel === 1'b1 && bus.rd === 1'b1 && bus.wr === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL read_unexpected: got 0x%08h expected no read", bus.data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        check(mon_exp.name, bus.data_out, mon_exp.val);
      end
    end
  end

  task automatic rd_reg(input logic sel, input string name, input logic [31:0] exp);
    bus.uart_sel = 1'b1;
    bus.rd       = 1'b1;
    bus.reg_sel  = sel;
    exp_q.push_back('{name, exp});
    @(posedge clk); #1;
    bus.uart_sel = 1'b0;
    bus.rd       = 1'b0;
    bus.reg_sel  = 1'b0;
  endtask

  // k counts clocks from the start-bit drive; stop sample falls in cycle k=154.
  task automatic send(input logic [7:0] b, input logic stop, input int read_k,
                      input logic [31:0] read_exp, input int rst_k, input bit chk_int);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k % CPB == 0) rx = bits[k / CPB];
      if (chk_int && k == 154) check("rx_int_at_stop_sample", 32'(bus.rx_int), 32'd0);
      if (chk_int && k == 155) check("rx_int_after_stop_sample", 32'(bus.rx_int), 32'd1);
      if (k == read_k) begin
        bus.uart_sel = 1'b1;
        bus.rd       = 1'b1;
        bus.reg_sel  = REG_DATA;
        exp_q.push_back('{"data_in_push_cycle", read_exp});
      end
      if (k == read_k + 1) begin
        bus.uart_sel = 1'b0;
        bus.rd       = 1'b0;
      end
      if (k == rst_k) rst = 1'b1;
      if (k == rst_k + 2) begin
        rst = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    rx = 1'b1;
  endtask

  initial begin
    rx           = 1'b1;
    rst          = 1'b1;
    bus.uart_sel = 1'b0;
    bus.rd       = 1'b0;
    bus.wr       = 1'b0;
    bus.reg_sel  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_rx_int", 32'(bus.rx_int), 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));
    rd_reg(REG_STATUS, "reset_status", 32'h0);
    rd_reg(REG_DATA, "empty_data", 32'h0);

    bus.uart_sel = 1'b1;
    bus.rd       = 1'b0;
    bus.reg_sel  = REG_STATUS;
    #1 check("sel_without_rd", bus.data_out, 32'd0);
    bus.rd = 1'b1;
    bus.wr = 1'b1;
    #1 check("write_not_a_read", bus.data_out, 32'd0);
    bus.uart_sel = 1'b0;
    bus.rd       = 1'b0;
    bus.wr       = 1'b0;
    bus.reg_sel  = 1'b0;
    @(posedge clk); #1;

    send(8'hA5, 1'b1, NONE, 32'h0, NONE, 1'b1);
    rd_reg(REG_DATA, "single_data", 32'h0000_00A5);
    check("single_int_cleared", 32'(bus.rx_int), 32'd0);

    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1 rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("false_start_state", 32'(dut.state), 32'(IDLE));
    check("false_start_int", 32'(bus.rx_int), 32'd0);
    rd_reg(REG_STATUS, "false_start_status", 32'h0);

    send(8'h3C, 1'b0, NONE, 32'h0, NONE, 1'b0);
    repeat (4) @(posedge clk);
    #1 check("frame_err_int", 32'(bus.rx_int), 32'd0);
    rd_reg(REG_STATUS, "frame_err_status", 32'h2);
    rd_reg(REG_STATUS, "frame_err_cleared", 32'h0);

`ifdef UART_RX_FIFO_EN
    send(8'h11, 1'b1, NONE, 32'h0, NONE, 1'b1);
    send(8'h22, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h33, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h44, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h55, 1'b1, NONE, 32'h0, NONE, 1'b0);
    rd_reg(REG_STATUS, "overrun_status", 32'h5);
    rd_reg(REG_DATA, "overrun_data0", 32'h11);
    rd_reg(REG_DATA, "overrun_data1", 32'h22);
    rd_reg(REG_DATA, "overrun_data2", 32'h33);
    rd_reg(REG_DATA, "overrun_data3", 32'h44);
    rd_reg(REG_STATUS, "overrun_cleared", 32'h0);

    send(8'h61, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h62, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h63, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h64, 1'b1, NONE, 32'h0, NONE, 1'b0);
    send(8'h77, 1'b1, 154, 32'h61, NONE, 1'b0);
    rd_reg(REG_STATUS, "pushpop_status", 32'h1);
    rd_reg(REG_DATA, "pushpop_data0", 32'h62);
    rd_reg(REG_DATA, "pushpop_data1", 32'h63);
    rd_reg(REG_DATA, "pushpop_data2", 32'h64);
    rd_reg(REG_DATA, "pushpop_new", 32'h77);
    rd_reg(REG_STATUS, "pushpop_empty", 32'h0);
`else
    send(8'h11, 1'b1, NONE, 32'h0, NONE, 1'b1);
    send(8'h22, 1'b1, NONE, 32'h0, NONE, 1'b0);
    rd_reg(REG_STATUS, "overrun_status", 32'h5);
    rd_reg(REG_DATA, "overrun_data", 32'h11);
    rd_reg(REG_STATUS, "overrun_cleared", 32'h0);

    send(8'h66, 1'b1, NONE, 32'h0, NONE, 1'b1);
    send(8'h77, 1'b1, 154, 32'h66, NONE, 1'b0);
    rd_reg(REG_STATUS, "pushpop_status", 32'h1);
    rd_reg(REG_DATA, "pushpop_new", 32'h77);
    rd_reg(REG_STATUS, "pushpop_empty", 32'h0);
`endif

    send(8'hFF, 1'b1, NONE, 32'h0, 70, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("midreset_state", 32'(dut.state), 32'(IDLE));
    check("midreset_int", 32'(bus.rx_int), 32'd0);
    send(8'h5A, 1'b1, NONE, 32'h0, NONE, 1'b1);
    rd_reg(REG_STATUS, "midreset_status", 32'h1);
    rd_reg(REG_DATA, "midreset_data", 32'h5A);
    rd_reg(REG_STATUS, "midreset_empty", 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: got no finish expected finish before 2 ms");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
